// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard sequencer: memory ops, FSM states, control bundle.
package pipe_hazard_ctrl_pkg;

    localparam int REG_W = 5;

    // Encoding 2'b11 is reserved and behaves as NONE.
    typedef enum logic [1:0] {
        MEMOP_NONE  = 2'b00,
        MEMOP_LOAD  = 2'b01,
        MEMOP_STORE = 2'b10
    } memop_e;

    typedef enum logic [1:0] {
        RUN,
        MEM_WAIT,
        DRAIN,
        HALTED
    } state_e;

    typedef struct packed {
        logic pc_stall;
        logic ifid_stall;
        logic ifid_flush;
        logic idex_stall;
        logic idex_flush;
        logic exmem_stall;
        logic exmem_flush;
        logic memwb_flush;
        logic halted;
    } ctrl_t;

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Load-use compare: a LOAD in EX whose destination feeds the instruction in decode.
module pipe_hazard_ctrl_hazard_detect
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [REG_W-1:0] ex_rd,
    input  logic [1:0]       ex_mem_op,
    output logic             lu
);

    assign lu = (ex_mem_op == MEMOP_LOAD) && (ex_rd != '0) &&
                ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                 (id_uses_rs2 && (id_rs2 == ex_rd)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline latch sequencer: Mealy stall/flush decode over a RUN/MEM_WAIT/DRAIN/HALTED FSM,
// with a memory-wait timeout (also armed while draining) and a saturating stall counter.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT  = 255,
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [REG_W-1:0] ex_rd,
    input  logic [1:0]       ex_mem_op,
    input  logic             ex_branch_taken,
    input  logic [1:0]       mem_mem_op,
    input  logic             dmem_ready,
    input  logic             halt_req,
    output logic             pc_stall,
    output logic             ifid_stall,
    output logic             ifid_flush,
    output logic             idex_stall,
    output logic             idex_flush,
    output logic             exmem_stall,
    output logic             exmem_flush,
    output logic             memwb_flush,
    output logic             halted,
    output logic             mem_fault,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int TO_W = $clog2(MEM_TIMEOUT + 1);
    localparam int DR_W = $clog2(DRAIN_CYCLES + 1);

    state_e          state, state_nx;
    logic [TO_W-1:0] tcnt, tcnt_nx;
    logic [DR_W-1:0] dcnt, dcnt_nx;
    logic            fault_set, mem_busy, lu, ex_act;
    ctrl_t           c;

    pipe_hazard_ctrl_hazard_detect u_hazard_detect (
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_uses_rs1 (id_uses_rs1),
        .id_uses_rs2 (id_uses_rs2),
        .ex_rd       (ex_rd),
        .ex_mem_op   (ex_mem_op),
        .lu          (lu)
    );

    assign mem_busy = ((mem_mem_op == MEMOP_LOAD) || (mem_mem_op == MEMOP_STORE)) && !dmem_ready;

    always_comb begin
        c         = '0;
        state_nx  = state;
        tcnt_nx   = tcnt;
        dcnt_nx   = dcnt;
        fault_set = 1'b0;
        ex_act    = 1'b0;
        case (state)
            RUN: begin
                if (mem_busy) begin
                    {c.pc_stall, c.ifid_stall, c.idex_stall, c.exmem_stall} = '1;
                    c.memwb_flush = 1'b1;
                    state_nx      = MEM_WAIT;
                    tcnt_nx       = TO_W'(1);
                end else begin
                    ex_act = 1'b1;
                    if (halt_req) begin
                        state_nx = DRAIN;
                        dcnt_nx  = '0;
                        tcnt_nx  = '0;
                    end
                end
            end
            MEM_WAIT: begin
                if (!mem_busy) begin
                    ex_act   = 1'b1;
                    state_nx = RUN;
                end else if (tcnt == TO_W'(MEM_TIMEOUT - 1)) begin
                    // Abandon the access: EX/MEM becomes a bubble, younger stages keep holding.
                    {c.pc_stall, c.ifid_stall, c.idex_stall} = '1;
                    c.exmem_flush = 1'b1;
                    c.memwb_flush = 1'b1;
                    fault_set     = 1'b1;
                    state_nx      = RUN;
                end else begin
                    {c.pc_stall, c.ifid_stall, c.idex_stall, c.exmem_stall} = '1;
                    c.memwb_flush = 1'b1;
                    tcnt_nx       = tcnt + 1'b1;
                end
            end
            DRAIN: begin
                c.pc_stall   = 1'b1;
                c.ifid_flush = 1'b1;
                if (mem_busy) begin
                    c.idex_stall  = 1'b1;
                    c.memwb_flush = 1'b1;
                    if (tcnt == TO_W'(MEM_TIMEOUT - 1)) begin
                        c.exmem_flush = 1'b1;
                        fault_set     = 1'b1;
                        tcnt_nx       = '0;
                    end else begin
                        c.exmem_stall = 1'b1;
                        tcnt_nx       = tcnt + 1'b1;
                    end
                end else begin
                    tcnt_nx = '0;
                    dcnt_nx = dcnt + 1'b1;
                    if (dcnt == DR_W'(DRAIN_CYCLES - 1))
                        state_nx = HALTED;
                end
            end
            HALTED: begin
                c.halted = 1'b1;
                {c.pc_stall, c.ifid_stall, c.idex_stall, c.exmem_stall} = '1;
                if (!halt_req)
                    state_nx = RUN;
            end
            default: state_nx = RUN;
        endcase
        // Branch redirect outranks the load-use bubble.
        if (ex_act) begin
            if (ex_branch_taken) begin
                c.ifid_flush = 1'b1;
                c.idex_flush = 1'b1;
            end else if (lu) begin
                c.pc_stall   = 1'b1;
                c.ifid_stall = 1'b1;
                c.idex_flush = 1'b1;
            end
        end
        if (reset)
            c = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= RUN;
            tcnt         <= '0;
            dcnt         <= '0;
            mem_fault    <= 1'b0;
            stall_cycles <= '0;
        end else begin
            state <= state_nx;
            tcnt  <= tcnt_nx;
            dcnt  <= dcnt_nx;
            if (fault_set)
                mem_fault <= 1'b1;
            if (c.pc_stall && (stall_cycles != {CNT_W{1'b1}}))
                stall_cycles <= stall_cycles + 1'b1;
        end
    end

    assign pc_stall    = c.pc_stall;
    assign ifid_stall  = c.ifid_stall;
    assign ifid_flush  = c.ifid_flush;
    assign idex_stall  = c.idex_stall;
    assign idex_flush  = c.idex_flush;
    assign exmem_stall = c.exmem_stall;
    assign exmem_flush = c.exmem_flush;
    assign memwb_flush = c.memwb_flush;
    assign halted      = c.halted;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios with literal expectations, then random traffic
// compared every cycle against a behavioural latch-hold/bubble model.
module tb_pipe_hazard_ctrl;

    localparam int TO   = 8;
    localparam int DR   = 3;
    localparam int CW   = 6;
    localparam int MAXC = (1 << CW) - 1;

    localparam int M_RUN = 0, M_WAIT = 1, M_DRAIN = 2, M_HALT = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic [4:0]    id_rs1, id_rs2, ex_rd;
    logic          id_uses_rs1, id_uses_rs2;
    logic [1:0]    ex_mem_op, mem_mem_op;
    logic          ex_branch_taken, dmem_ready, halt_req;
    logic          pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush;
    logic          exmem_stall, exmem_flush, memwb_flush, halted, mem_fault;
    logic [CW-1:0] stall_cycles;

    int checks = 0;
    int errors = 0;

    int m_mode, m_busy, m_drained, m_stalls;
    bit m_fault;
    bit m_valid = 1'b0;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(TO), .DRAIN_CYCLES(DR), .CNT_W(CW)) dut (
        .clk             (clk),
        .reset           (reset),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_uses_rs1     (id_uses_rs1),
        .id_uses_rs2     (id_uses_rs2),
        .ex_rd           (ex_rd),
        .ex_mem_op       (ex_mem_op),
        .ex_branch_taken (ex_branch_taken),
        .mem_mem_op      (mem_mem_op),
        .dmem_ready      (dmem_ready),
        .halt_req        (halt_req),
        .pc_stall        (pc_stall),
        .ifid_stall      (ifid_stall),
        .ifid_flush      (ifid_flush),
        .idex_stall      (idex_stall),
        .idex_flush      (idex_flush),
        .exmem_stall     (exmem_stall),
        .exmem_flush     (exmem_flush),
        .memwb_flush     (memwb_flush),
        .halted          (halted),
        .mem_fault       (mem_fault),
        .stall_cycles    (stall_cycles)
    );

    always #5 clk = ~clk;

    // Stages indexed 0 pc, 1 if/id, 2 id/ex, 3 ex/mem, 4 mem/wb: hold = stall, bub = flush.
    function automatic void model_eval(output bit [8:0] e, output int nmode, output int nbusy,
                                       output int ndrained, output bit fault_now);
        bit [4:0] hold, bub;
        bit busy, lu, use_ex, hl;
        busy = ((mem_mem_op == 2'd1) || (mem_mem_op == 2'd2)) && !dmem_ready;
        lu   = (ex_mem_op == 2'd1) && (ex_rd != 0) &&
               ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
        hold = '0; bub = '0; hl = 0; use_ex = 0; fault_now = 0;
        nmode = m_mode; nbusy = m_busy; ndrained = m_drained;
        case (m_mode)
            M_RUN:
                if (busy) begin
                    hold = 5'b01111; bub[4] = 1; nmode = M_WAIT; nbusy = 1;
                end else begin
                    use_ex = 1;
                    if (halt_req) begin nmode = M_DRAIN; ndrained = 0; nbusy = 0; end
                end
            M_WAIT:
                if (!busy) begin
                    use_ex = 1; nmode = M_RUN;
                end else begin
                    hold = 5'b01111; bub[4] = 1;
                    if (m_busy + 1 >= TO) begin bub[3] = 1; fault_now = 1; nmode = M_RUN; end
                    else nbusy = m_busy + 1;
                end
            M_DRAIN: begin
                hold[0] = 1; bub[1] = 1;
                if (busy) begin
                    hold[3:2] = 2'b11; bub[4] = 1;
                    if (m_busy + 1 >= TO) begin bub[3] = 1; fault_now = 1; nbusy = 0; end
                    else nbusy = m_busy + 1;
                end else begin
                    nbusy = 0; ndrained = m_drained + 1;
                    if (ndrained >= DR) nmode = M_HALT;
                end
            end
            default: begin
                hold = 5'b01111; hl = 1;
                if (!halt_req) nmode = M_RUN;
            end
        endcase
        if (use_ex) begin
            if (ex_branch_taken) bub[2:1] = 2'b11;
            else if (lu) begin hold[1:0] = 2'b11; bub[2] = 1; end
        end
        hold = hold & ~bub;
        if (reset) begin hold = '0; bub = '0; hl = 0; end
        e = {hold[0], hold[1], bub[1], hold[2], bub[2], hold[3], bub[3], bub[4], hl};
    endfunction

    // Model state advance on each active edge.
    initial forever begin
        bit [8:0] e;
        int nm, nb, nd;
        bit fn;
        @(posedge clk);
        model_eval(e, nm, nb, nd, fn);
        if (reset) begin
            m_mode = M_RUN; m_busy = 0; m_drained = 0; m_fault = 0; m_stalls = 0; m_valid = 1;
        end else if (m_valid) begin
            m_mode = nm; m_busy = nb; m_drained = nd;
            if (fn) m_fault = 1;
            if (e[8] && m_stalls < MAXC) m_stalls = m_stalls + 1;
        end
    end

    // Every-cycle comparison against the model.
    initial forever begin
        bit [8:0] e, act;
        int nm, nb, nd;
        bit fn;
        @(negedge clk);
        if (m_valid || reset) begin
            model_eval(e, nm, nb, nd, fn);
            act = {pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush,
                   exmem_stall, exmem_flush, memwb_flush, halted};
            checks++;
            if (act !== e) begin
                errors++;
                $display("FAIL ctrl_vec t=%0t got %b want %b", $time, act, e);
            end
        end
        if (m_valid) begin
            checks++;
            if (mem_fault !== m_fault || stall_cycles !== CW'(m_stalls)) begin
                errors++;
                $display("FAIL regs t=%0t got fault=%0b cnt=%0d want fault=%0b cnt=%0d",
                         $time, mem_fault, stall_cycles, m_fault, m_stalls);
            end
        end
    end

    task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got %0d want %0d", nm, $time, act, exp);
        end
    endtask

    task automatic idle();
        id_rs1 = 5'd1; id_rs2 = 5'd2; id_uses_rs1 = 0; id_uses_rs2 = 0;
        ex_rd = 5'd0; ex_mem_op = 2'd0; ex_branch_taken = 0;
        mem_mem_op = 2'd0; dmem_ready = 1; halt_req = 0;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lu(input logic [4:0] rd);
        ex_mem_op = 2'd1; ex_rd = rd; id_rs2 = 5'd5; id_uses_rs2 = 1;
    endtask

    initial begin
        reset = 1;
        idle();
        nxt(); nxt();
        @(negedge clk);
        lit("rst_pc_stall", pc_stall, 0);
        lit("rst_halted", halted, 0);
        lit("rst_cnt", stall_cycles, 0);
        lit("rst_fault", mem_fault, 0);
        nxt();
        reset = 0;

        // Load-use, then the same with rd=x0.
        set_lu(5'd5);
        @(negedge clk);
        lit("lu_pc", pc_stall, 1); lit("lu_ifid", ifid_stall, 1); lit("lu_idexf", idex_flush, 1);
        nxt(); idle();
        @(negedge clk);
        lit("lu_once", pc_stall, 0); lit("lu_cnt", stall_cycles, 1);
        nxt(); set_lu(5'd0);
        @(negedge clk);
        lit("lu_x0", pc_stall, 0);
        nxt(); idle();

        // Store waits four cycles then completes.
        mem_mem_op = 2'd2; dmem_ready = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            lit("wait_pc", pc_stall, 1); lit("wait_wbf", memwb_flush, 1);
            nxt();
        end
        dmem_ready = 1;
        @(negedge clk);
        lit("wait_rel", pc_stall, 0);
        nxt(); idle();
        @(negedge clk);
        lit("wait_cnt", stall_cycles, 5);
        nxt();

        // Branch beats load-use; branch ignored while waiting on memory.
        set_lu(5'd5); ex_branch_taken = 1;
        @(negedge clk);
        lit("br_ifidf", ifid_flush, 1); lit("br_idexf", idex_flush, 1); lit("br_pc", pc_stall, 0);
        nxt(); idle();
        ex_branch_taken = 1; mem_mem_op = 2'd2; dmem_ready = 0;
        @(negedge clk);
        lit("brw0_ifidf", ifid_flush, 0); lit("brw0_pc", pc_stall, 1);
        nxt();
        @(negedge clk);
        lit("brw1_ifidf", ifid_flush, 0);
        nxt(); dmem_ready = 1;
        @(negedge clk);
        lit("brrel_ifidf", ifid_flush, 1); lit("brrel_pc", pc_stall, 0);
        nxt(); idle();

        // Load never completes: timeout on the eighth busy cycle.
        mem_mem_op = 2'd1; dmem_ready = 0;
        for (int i = 1; i <= TO; i++) begin
            @(negedge clk);
            if (i == TO - 1) lit("to7_exf", exmem_flush, 0);
            if (i == TO) begin
                lit("to8_exf", exmem_flush, 1); lit("to8_exs", exmem_stall, 0);
                lit("to8_fault", mem_fault, 0);
            end
            nxt();
        end
        idle();
        @(negedge clk);
        lit("to_fault", mem_fault, 1); lit("to_run", pc_stall, 0);
        nxt();

        // Halt: three drain cycles then halted until halt_req drops.
        halt_req = 1;
        @(negedge clk);
        lit("h_run_pc", pc_stall, 0);
        nxt();
        for (int i = 0; i < DR; i++) begin
            @(negedge clk);
            lit("drain_pc", pc_stall, 1); lit("drain_ifidf", ifid_flush, 1); lit("drain_h", halted, 0);
            nxt();
        end
        @(negedge clk);
        lit("halted", halted, 1); lit("halted_ifids", ifid_stall, 1);
        nxt(); halt_req = 0;
        @(negedge clk);
        lit("unhalt_same", halted, 1);
        nxt();
        @(negedge clk);
        lit("unhalt_h", halted, 0); lit("unhalt_pc", pc_stall, 0);
        nxt();

        // Reset while in MEM_WAIT with the fault flag set.
        mem_mem_op = 2'd1; dmem_ready = 0;
        nxt(); nxt();
        reset = 1;
        @(negedge clk);
        lit("rstw_pc", pc_stall, 0); lit("rstw_wbf", memwb_flush, 0); lit("rstw_fault_pre", mem_fault, 1);
        nxt(); reset = 0; idle();
        @(negedge clk);
        lit("rstw_cnt", stall_cycles, 0); lit("rstw_fault", mem_fault, 0); lit("rstw_pc2", pc_stall, 0);
        nxt();

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            id_rs1 = 5'($urandom_range(0, 3));
            id_rs2 = 5'($urandom_range(0, 3));
            ex_rd  = 5'($urandom_range(0, 3));
            id_uses_rs1 = 1'($urandom_range(0, 1));
            id_uses_rs2 = 1'($urandom_range(0, 1));
            ex_mem_op = 2'($urandom_range(0, 3));
            ex_branch_taken = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 4) == 0) mem_mem_op = 2'($urandom_range(0, 3));
            dmem_ready = ($urandom_range(0, 9) < 4);
            if ($urandom_range(0, 99) < 3) halt_req = ~halt_req;
            reset = ($urandom_range(0, 199) == 0);
            nxt();
        end
        reset = 0; idle();
        nxt();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
